// File: rtl/sine_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sine_sched_pkg
// Description : Shared constants, channel state type and index helpers for
//               the sine channel scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package sine_sched_pkg;

  localparam int TABLE_SIZE = 32;
  localparam int IDX_W      = 5;
  localparam int SINE_W     = 8;
  localparam int PHASE_W    = 9;

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(TABLE_SIZE - 1);
  localparam logic [IDX_W-1:0] IDX_MID = IDX_W'(TABLE_SIZE / 2);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } dir_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    dir_t             dir;
  } chan_state_t;

  // Mid-table plus signed offset, folded at 0 and clamped at the top entry.
  function automatic chan_state_t start_index(input logic [PHASE_W-1:0] phase);
    logic signed [PHASE_W:0] s;
    chan_state_t             st;
    s = $signed({1'b0, PHASE_W'(TABLE_SIZE / 2)}) + $signed({phase[PHASE_W-1], phase});
    if (s[PHASE_W]) begin
      s = -s;
    end
    if (s > $signed((PHASE_W + 1)'(TABLE_SIZE - 1))) begin
      st.idx = IDX_MAX;
    end else begin
      st.idx = s[IDX_W-1:0];
    end
    st.dir = phase[PHASE_W-1] ? DIR_REV : DIR_FWD;
    if (st.idx == IDX_MAX) begin
      st.dir = DIR_REV;
    end else if (st.idx == '0) begin
      st.dir = DIR_FWD;
    end
    return st;
  endfunction

  // Bounce traversal: each endpoint is visited once before turning around.
  function automatic chan_state_t advance(input chan_state_t cur);
    chan_state_t nxt;
    nxt = cur;
    if (cur.dir == DIR_FWD) begin
      if (cur.idx == IDX_MAX) begin
        nxt.idx = cur.idx - IDX_ONE;
        nxt.dir = DIR_REV;
      end else begin
        nxt.idx = cur.idx + IDX_ONE;
      end
    end else begin
      if (cur.idx == '0) begin
        nxt.idx = cur.idx + IDX_ONE;
        nxt.dir = DIR_FWD;
      end else begin
        nxt.idx = cur.idx - IDX_ONE;
      end
    end
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin search starting at ptr, ascending
//               with wrap; returns one-hot grant, winner id and any-flag.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_id,
  output logic              any
);

  logic [CH_W-1:0] w_cand;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    w_cand   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cand = CH_W'((int'(ptr) + i) % NUM_CH);
      if (!any && req[w_cand]) begin
        grant[w_cand] = 1'b1;
        grant_id      = w_cand;
        any           = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sine_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sine_channel_scheduler
// Description : Shares one half-sine table read port between NUM_CH bouncing
//               sine channels via round-robin; samples return tagged by channel.
// Revision    : 1.0 - initial release
// ============================================================================
module sine_channel_scheduler
  import sine_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   ch_enable,
  input  logic [NUM_CH-1:0]   ch_req,
  output logic [NUM_CH-1:0]   ch_ack,
  input  logic                cfg_wr,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [PHASE_W-1:0]  cfg_phase,
  output logic [IDX_W-1:0]    tbl_addr,
  input  logic [SINE_W-1:0]   tbl_data,
  output logic [SINE_W-1:0]   sample_out,
  output logic [CH_W-1:0]     sample_ch,
  output logic                sample_valid
);

  chan_state_t         r_chan [NUM_CH];
  logic [CH_W-1:0]     r_ptr;
  logic                r_s1_valid;
  logic [CH_W-1:0]     r_s1_ch;

  logic [NUM_CH-1:0]   w_elig;
  logic [NUM_CH-1:0]   w_grant;
  logic [CH_W-1:0]     w_win;
  logic                w_any;
  logic [CH_W-1:0]     w_ptr_next;
  chan_state_t         w_load;

  assign w_elig     = ch_req & ch_enable;
  assign w_ptr_next = (w_win == CH_W'(NUM_CH - 1)) ? '0 : w_win + CH_W'(1);
  assign w_load     = start_index(cfg_phase);

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .req      (w_elig),
    .ptr      (r_ptr),
    .grant    (w_grant),
    .grant_id (w_win),
    .any      (w_any)
  );

  // A phase load takes priority over the advance of a same-cycle grant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_chan[c] <= '{idx: IDX_MID, dir: DIR_FWD};
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_wr && (cfg_ch == CH_W'(c))) begin
          r_chan[c] <= w_load;
        end else if (w_grant[c]) begin
          r_chan[c] <= advance(r_chan[c]);
        end
      end
    end
  end

  // Stage 0: grant and table address; stage 1: capture the table output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ch_ack       <= '0;
      tbl_addr     <= '0;
      r_ptr        <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_ch      <= '0;
      sample_out   <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
    end else begin
      ch_ack     <= w_grant;
      r_s1_valid <= w_any;
      if (w_any) begin
        tbl_addr <= r_chan[w_win].idx;
        r_s1_ch  <= w_win;
        r_ptr    <= w_ptr_next;
      end
      sample_valid <= r_s1_valid;
      if (r_s1_valid) begin
        sample_out <= tbl_data;
        sample_ch  <= r_s1_ch;
      end
    end
  end

endmodule
`default_nettype wire
